// File: rtl/struct_field_pkg.sv
// Shared types for the packed-struct field serializer: FSM states and the
// field index that tags each output beat.
package struct_field_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
  } state_e;

  typedef enum logic {
    FIELD_IDX0 = 1'b0,
    FIELD_IDX1 = 1'b1
  } field_idx_e;

endpackage

// File: rtl/struct_field_serializer.sv
// Accepts one packed two-field struct word per handshake and replays its
// fields, field0 first, as zero-extended beats on a narrower output lane.
module struct_field_serializer
  import struct_field_pkg::*;
#(
  parameter int FIELD0_WIDTH = 4,
  parameter int FIELD1_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FIELD0_WIDTH+FIELD1_WIDTH-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [((FIELD0_WIDTH > FIELD1_WIDTH) ? FIELD0_WIDTH : FIELD1_WIDTH)-1:0] out_data,
  output logic                                 out_idx,
  output logic                                 out_last
);

  localparam int OUT_WIDTH = (FIELD0_WIDTH > FIELD1_WIDTH) ? FIELD0_WIDTH : FIELD1_WIDTH;

  // Field0 occupies the MSB side, matching the slice-based writers.
  typedef struct packed {
    logic [FIELD0_WIDTH-1:0] field0;
    logic [FIELD1_WIDTH-1:0] field1;
  } word_t;

  function automatic logic [OUT_WIDTH-1:0] zext_field0(input word_t w);
    return OUT_WIDTH'(w.field0);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] zext_field1(input word_t w);
    return OUT_WIDTH'(w.field1);
  endfunction

  state_e                 state_q, state_d;
  word_t                  hold_q, hold_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  field_idx_e             out_idx_q, out_idx_d;
  logic                   out_last_q, out_last_d;
  word_t                  in_word;
  logic                   accept;

  assign in_word = word_t'(in_data);

  // Ready depends only on state and out_ready so producers may wait on it.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        EMIT1:   in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d      = in_word;
          state_d     = EMIT0;
          out_valid_d = 1'b1;
          out_data_d  = zext_field0(in_word);
          out_idx_d   = FIELD_IDX0;
          out_last_d  = 1'b0;
        end
      end

      EMIT0: begin
        if (out_ready) begin
          state_d    = EMIT1;
          out_data_d = zext_field1(hold_q);
          out_idx_d  = FIELD_IDX1;
          out_last_d = 1'b1;
        end
      end

      EMIT1: begin
        if (out_ready) begin
          if (accept) begin
            // Back-to-back word: field0 of the next word follows with no bubble.
            hold_d      = in_word;
            state_d     = EMIT0;
            out_valid_d = 1'b1;
            out_data_d  = zext_field0(in_word);
            out_idx_d   = FIELD_IDX0;
            out_last_d  = 1'b0;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = FIELD_IDX0;
            out_last_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_idx_d   = FIELD_IDX0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= FIELD_IDX0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

  // Field extraction must agree with the packing of the held word.
  always_comb begin
    assert (out_last === out_idx)
      else $error("out_last disagrees with out_idx");
    if (state_q == EMIT0) begin
      assert (out_data_q == zext_field0(hold_q))
        else $error("field0 beat does not match held word");
    end
    if (state_q == EMIT1) begin
      assert (out_data_q == zext_field1(hold_q))
        else $error("field1 beat does not match held word");
    end
  end

endmodule

// File: tb/tb_struct_field_serializer.sv
// Randomized and directed bench for struct_field_serializer; beats are
// predicted by a queue model of the field stream.
module tb_struct_field_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Default 4/4 layout
  logic       in_valid, in_ready, out_valid, out_ready, out_idx, out_last;
  logic [7:0] in_data;
  logic [3:0] out_data;

  // 3/5 layout
  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_idx_b, out_last_b;
  logic [7:0] in_data_b;
  logic [4:0] out_data_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] data;
    logic       idx;
    logic       last;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  struct_field_serializer #(.FIELD0_WIDTH(4), .FIELD1_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  struct_field_serializer #(.FIELD0_WIDTH(3), .FIELD1_WIDTH(5)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b),
    .out_idx   (out_idx_b),
    .out_last  (out_last_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of the 4/4 instance: drive at negedge, compare against the
  // beat queue, then apply the handshakes that happen at the next posedge.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                      output logic accepted);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(exp_q[0].data));
      check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
      check("out_last", 32'(out_last), 32'(exp_q[0].last));
    end else begin
      check("idle_data", 32'(out_data), 32'(0));
      check("idle_last", 32'(out_last), 32'(0));
    end
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    accepted = iv && exp_rdy;
    if (accepted) begin
      exp_q.push_back('{id[7:4], 1'b0, 1'b0});
      exp_q.push_back('{id[3:0], 1'b1, 1'b1});
    end
  endtask

  task automatic idle_steps(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, acc);
  endtask

  initial begin
    logic       acc;
    logic       have;
    logic [7:0] word;
    logic [7:0] words [4];
    int         k;

    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_idx", 32'(out_idx), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Asymmetric 3/5 layout
    @(negedge clk);
    in_valid_b = 1'b1;
    in_data_b  = 8'b101_10011;
    #1 check("b_in_ready", 32'(in_ready_b), 32'(1));
    @(negedge clk);
    in_valid_b = 1'b0;
    #1;
    check("b_valid0", 32'(out_valid_b), 32'(1));
    check("b_data0", 32'(out_data_b), 32'(5'b00101));
    check("b_idx0", 32'(out_idx_b), 32'(0));
    check("b_last0", 32'(out_last_b), 32'(0));
    @(negedge clk);
    #1;
    check("b_valid1", 32'(out_valid_b), 32'(1));
    check("b_data1", 32'(out_data_b), 32'(5'b10011));
    check("b_idx1", 32'(out_idx_b), 32'(1));
    check("b_last1", 32'(out_last_b), 32'(1));
    @(negedge clk);
    #1 check("b_valid_done", 32'(out_valid_b), 32'(0));

    // Idle after reset
    idle_steps(10);

    // Single word, no backpressure
    step(1'b1, 8'hA5, 1'b1, acc);
    check("a5_accepted", 32'(acc), 32'(1));
    idle_steps(3);

    // Backpressure on field0 of 8'h3C with 8'hF0 waiting
    step(1'b1, 8'h3C, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hF0, 1'b0, acc);
    step(1'b1, 8'hF0, 1'b1, acc);
    step(1'b1, 8'hF0, 1'b1, acc);
    check("f0_accepted_on_c", 32'(acc), 32'(1));
    idle_steps(3);

    // Streaming four words
    words = '{8'h11, 8'h2E, 8'hD3, 8'h4B};
    k = 0;
    for (int i = 0; i < 8; i++) begin
      step(k < 4, (k < 4) ? words[k] : 8'h00, 1'b1, acc);
      if (acc) k++;
    end
    check("stream_words", 32'(k), 32'(4));
    idle_steps(3);

    // Random traffic; the producer holds its word until accepted
    have = 1'b0;
    word = '0;
    for (int i = 0; i < 400; i++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        have = 1'b1;
        word = 8'($urandom);
      end
      step(have, have ? word : 8'($urandom), $urandom_range(0, 3) != 0, acc);
      if (acc) have = 1'b0;
    end
    in_valid = 1'b0;
    idle_steps(4);

    // Reset during the field1 beat of 8'h77
    step(1'b1, 8'h77, 1'b1, acc);
    step(1'b0, 8'h00, 1'b1, acc);
    @(posedge clk);
    #2;
    check("pre_rst_last", 32'(out_last), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_data", 32'(out_data), 32'(0));
    check("mid_rst_last", 32'(out_last), 32'(0));
    check("mid_rst_ready", 32'(in_ready), 32'(0));
    exp_q.delete();
    @(posedge clk);
    #2 check("held_rst_valid", 32'(out_valid), 32'(0));
    #1 rst_n = 1'b1;
    idle_steps(2);
    step(1'b1, 8'h12, 1'b1, acc);
    check("post_rst_accept", 32'(acc), 32'(1));
    idle_steps(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
